// File: rtl/mem_mode_engine_pkg.sv
// Shared types for the multi-mode storage responder (package mem_pkg).
// Holds the mode, rw and FSM encodings plus the default data width.
package mem_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    FIFO = 3'b000,
    LIFO = 3'b001,
    RING = 3'b010
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR   = 2'b01,
    RD   = 2'b10,
    RW   = 2'b11
  } rw_e;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic logic mode_valid(input logic [2:0] m);
    case (m)
      FIFO, LIFO, RING: mode_valid = 1'b1;
      default:          mode_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_mode_engine_if.sv
// Stimulus-side bus of the storage responder; err exists only when
// MEM_MODE_ERR_EN is defined.
interface mem_mode_engine_if #(
  parameter int DATA_W = mem_pkg::DATA_W_DEF
);
  logic [DATA_W-1:0] Din;
  logic [2:0]        mode_in;
  logic [2:0]        chip_en;
  logic [1:0]        rw;
  logic [DATA_W-1:0] Dout;
  logic              full;
  logic              empty;
`ifdef MEM_MODE_ERR_EN
  logic              err;

  modport master (output Din, mode_in, chip_en, rw, input Dout, full, empty, err);
  modport slave  (input Din, mode_in, chip_en, rw, output Dout, full, empty, err);
`else
  modport master (output Din, mode_in, chip_en, rw, input Dout, full, empty);
  modport slave  (input Din, mode_in, chip_en, rw, output Dout, full, empty);
`endif
endinterface

// File: rtl/mem_mode_engine_storage.sv
// DEPTH x DATA_W register array, one write port and one registered read port.
// A same-address read/write collision returns the previous contents.
module mem_storage #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem_r [DEPTH];

  // array write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // read register, holds its value between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end
endmodule

// File: rtl/mem_mode_engine.sv
// FIFO / LIFO / overwrite-ring responder over one storage array.
// Optional sticky err output is enabled by defining MEM_MODE_ERR_EN.
module mem_mode_engine
  import mem_pkg::*;
#(
  parameter int          DATA_W  = DATA_W_DEF,
  parameter int          DEPTH   = 16,
  parameter logic [2:0]  CHIP_ID = 3'b001
) (
  input  logic           clk,
  input  logic           reset,
  mem_mode_engine_if.slave bus
);
  localparam int              ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  state_e              state_r, state_s;
  mode_e               mode_q_r, mode_q_s, op_mode_s;
  logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
  logic [ADDR_W:0]     count_r, count_s;
  logic                full_r, empty_r;
  logic                req_s, ok_s, match_s, is_full_s, is_empty_s;
  logic                we_s, re_s;
  logic [ADDR_W-1:0]   waddr_s, raddr_s;
  logic [DATA_W-1:0]   dout_s;

  assign req_s      = !reset && (bus.chip_en == CHIP_ID) && (bus.rw != IDLE);
  assign ok_s       = mode_valid(bus.mode_in);
  assign match_s    = (state_r == ST_EMPTY) || (bus.mode_in == mode_q_r);
  assign is_full_s  = (count_r == CNT_FULL);
  assign is_empty_s = (count_r == CNT_ZERO);
  assign op_mode_s  = mode_e'(bus.mode_in);

  // next-state, pointer, count and storage-port decode
  always_comb begin
    state_s  = state_r;
    mode_q_s = mode_q_r;
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    count_s  = count_r;
    we_s     = 1'b0;
    re_s     = 1'b0;
    waddr_s  = wr_ptr_r;
    raddr_s  = rd_ptr_r;
    if (req_s && ok_s && match_s) begin
      if (state_r == ST_EMPTY) begin
        mode_q_s = op_mode_s;
      end else begin
        mode_q_s = mode_q_r;
      end
      case (bus.rw)
        WR: begin
          if (!is_full_s) begin
            we_s     = 1'b1;
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            count_s  = count_r + CNT_ONE;
          end else if (op_mode_s == RING) begin
            // overwrite the oldest entry; occupancy stays at DEPTH
            we_s     = 1'b1;
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            rd_ptr_s = rd_ptr_r + PTR_ONE;
          end else begin
            we_s = 1'b0;
          end
        end
        RD: begin
          if (is_empty_s) begin
            re_s = 1'b0;
          end else if (op_mode_s == LIFO) begin
            re_s     = 1'b1;
            raddr_s  = wr_ptr_r - PTR_ONE;
            wr_ptr_s = wr_ptr_r - PTR_ONE;
            count_s  = count_r - CNT_ONE;
          end else begin
            re_s     = 1'b1;
            rd_ptr_s = rd_ptr_r + PTR_ONE;
            count_s  = count_r - CNT_ONE;
          end
        end
        RW: begin
          if (is_empty_s) begin
            we_s     = 1'b1;
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            count_s  = count_r + CNT_ONE;
          end else if (op_mode_s == LIFO) begin
            // swap the top: read-before-write on the same address
            re_s    = 1'b1;
            we_s    = 1'b1;
            raddr_s = wr_ptr_r - PTR_ONE;
            waddr_s = wr_ptr_r - PTR_ONE;
          end else begin
            re_s     = 1'b1;
            we_s     = 1'b1;
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            rd_ptr_s = rd_ptr_r + PTR_ONE;
          end
        end
        default: begin
          we_s = 1'b0;
          re_s = 1'b0;
        end
      endcase
      state_s = (count_s == CNT_ZERO) ? ST_EMPTY : ST_ACTIVE;
    end else begin
      state_s = state_r;
    end
  end

  // state, pointer and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_EMPTY;
      mode_q_r <= FIFO;
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      mode_q_r <= mode_q_s;
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      full_r   <= (count_s == CNT_FULL);
      empty_r  <= (count_s == CNT_ZERO);
    end
  end

  mem_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (bus.Din),
    .re    (re_s),
    .raddr (raddr_s),
    .rdata (dout_s)
  );

  assign bus.Dout  = dout_s;
  assign bus.full  = full_r;
  assign bus.empty = empty_r;

`ifdef MEM_MODE_ERR_EN
  logic err_r, err_set_s;

  // error conditions: reserved mode, mode mismatch, dropped write/read
  always_comb begin
    err_set_s = 1'b0;
    if (req_s) begin
      if (!ok_s || !match_s) begin
        err_set_s = 1'b1;
      end else if ((bus.rw == WR) && is_full_s && (op_mode_s != RING)) begin
        err_set_s = 1'b1;
      end else if ((bus.rw == RD) && is_empty_s) begin
        err_set_s = 1'b1;
      end else begin
        err_set_s = 1'b0;
      end
    end else begin
      err_set_s = 1'b0;
    end
  end

  // sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.err = err_r;
`endif
endmodule
